// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter/sequencer: op codes, op classification
// and controller FSM state encoding.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHR  = 4'b0110;
  localparam logic [3:0] OP_ROL  = 4'b0111;
  localparam logic [3:0] OP_ROR  = 4'b1000;
  localparam logic [3:0] OP_LAST = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  // Shift/rotate ops honour the repeat count; everything else is one pass.
  function automatic logic is_multipass(input logic [3:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_arb_seq_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester preferred on a tie
// and moves to the loser after every granted transfer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Requester 0 winning hands priority to requester 1 and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (grant != 2'b00)) begin
      ptr_d = grant[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arb_seq.sv
// Shares one combinational 4-bit ALU between two requesters: round-robin accept,
// iterated shift/rotate passes, registered result on a valid/ready channel.
module alu_arb_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [3:0]    req0_op,
  input  logic [3:0]    req1_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req0_b,
  input  logic [DW-1:0] req1_b,
  input  logic [CW-1:0] req0_cnt,
  input  logic [CW-1:0] req1_cnt,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  input  logic          alu_zero,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_carry,
  output logic          rsp_zero,
  output logic          rsp_err
);

  // Pass counter must hold 2^CW, one bit wider than the count field.
  localparam int unsigned PW = CW + 1;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic            id_q, id_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_err_q, rsp_err_d;

  logic [1:0]      grant;
  logic            accept;
  logic            win_id;
  logic [3:0]      sel_op;
  logic [DW-1:0]   sel_a, sel_b;
  logic [CW-1:0]   sel_cnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign req_ready = (state_q == StIdle) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign win_id    = grant[1];
  assign sel_op    = win_id ? req1_op  : req0_op;
  assign sel_a     = win_id ? req1_a   : req0_a;
  assign sel_b     = win_id ? req1_b   : req0_b;
  assign sel_cnt   = win_id ? req1_cnt : req0_cnt;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    pass_d      = pass_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = sel_op;
          a_d    = sel_a;
          b_d    = sel_b;
          id_d   = win_id;
          pass_d = is_multipass(sel_op) ? ({1'b0, sel_cnt} + PW'(1)) : PW'(1);
          if (is_legal(sel_op)) begin
            state_d = StExec;
          end else begin
            // Illegal op never touches the ALU; respond straight away.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_id;
            rsp_data_d  = '0;
            rsp_carry_d = 1'b0;
            rsp_zero_d  = 1'b0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      StExec: begin
        a_d    = alu_out;
        pass_d = pass_q - PW'(1);
        if (pass_q == PW'(1)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = alu_out;
          rsp_carry_d = alu_carry;
          rsp_zero_d  = alu_zero;
          rsp_err_d   = 1'b0;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      pass_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      pass_q      <= pass_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // ALU lines are only live while executing.
  assign alu_sel   = (state_q == StExec) ? op_q : 4'b0000;
  assign alu_a     = (state_q == StExec) ? a_q  : '0;
  assign alu_b     = (state_q == StExec) ? b_q  : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

endmodule
